// File: rtl/shift_rx32.sv
// shift_rx32 -- serial-to-parallel receiver for the 32-bit shift-register link.
//
// Collects one bit per sin_valid clock into a WIDTH-bit shift register, LSB-first
// (dir=0) or MSB-first (dir=1). The direction is latched on the first bit of each
// word. A completed word moves into the registered parallel output po and raises
// po_valid until the consumer accepts it with po_ready.
//
// The output register acts as a one-word holding slot. The next word can
// assemble while po waits to be accepted. If a word completes while the slot is
// still full and not being drained, that word is dropped and overrun is set.
// overrun is sticky until reset.
//
// Optional feature macro: SHIFT_RX_PARITY_EN
//   Defined:   each word is followed by one even-parity bit. That bit is counted
//              but not shifted into the word. parity_err is loaded alongside po.
//   Undefined: words complete on bit WIDTH and parity_err is constant 0.
//
// Reset is asynchronous and active-low on the port named 'reset'.

module shift_rx32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             dir,
    input  logic             clear,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             overrun,
    output logic             busy,
    output logic             parity_err
);

`ifdef SHIFT_RX_PARITY_EN
    localparam int LAST = WIDTH + 1;
`else
    localparam int LAST = WIDTH;
`endif
    localparam int CW = $clog2(LAST + 1);

    localparam logic [CW-1:0] CNT_ZERO  = '0;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FINAL = CW'(LAST - 1);
`ifdef SHIFT_RX_PARITY_EN
    localparam logic [CW-1:0] CNT_DATA  = CW'(WIDTH);
`endif

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_ASSEMBLE = 1'b1;

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    cnt;
    logic [0:0]       state;
    logic             dir_q;
    logic             eff_dir;
    logic             take;
    logic             data_bit;
    logic             complete;
    logic             transfer;
    logic             accept;
`ifdef SHIFT_RX_PARITY_EN
    logic             par_acc;
    logic             word_perr;
    logic             perr_q;
`endif

    // The state follows directly from the bit counter. IDLE means no bits of the current word have arrived yet.
    always_comb begin
        state = (cnt == CNT_ZERO) ? ST_IDLE : ST_ASSEMBLE;
    end

    // Per-edge decode: whether this bit is taken, which direction applies, and whether the word finishes and lands in po.
    always_comb begin
        take     = sin_valid && !clear;
        eff_dir  = (state == ST_IDLE) ? dir : dir_q;
        complete = take && (cnt == CNT_FINAL);
        shifted  = eff_dir ? {sreg[WIDTH-2:0], sin} : {sin, sreg[WIDTH-1:1]};
        transfer = po_valid && po_ready;
        accept   = complete && (!po_valid || po_ready);
`ifdef SHIFT_RX_PARITY_EN
        data_bit  = take && (cnt < CNT_DATA);
        word      = sreg;
        word_perr = par_acc ^ sin;
`else
        data_bit  = take;
        word      = shifted;
`endif
    end

    // Assembly datapath. clear wins over sin_valid and discards the bit sampled on that edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg  <= '0;
            cnt   <= CNT_ZERO;
            dir_q <= 1'b0;
        end else if (clear) begin
            sreg <= '0;
            cnt  <= CNT_ZERO;
        end else if (sin_valid) begin
            if (state == ST_IDLE) begin
                dir_q <= dir;
            end
            if (data_bit) begin
                sreg <= shifted;
            end
            cnt <= complete ? CNT_ZERO : cnt + CNT_ONE;
        end
    end

`ifdef SHIFT_RX_PARITY_EN
    // Running XOR of the data bits of the word in progress. It restarts at every word boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_acc <= 1'b0;
        end else if (clear || complete) begin
            par_acc <= 1'b0;
        end else if (data_bit) begin
            par_acc <= par_acc ^ sin;
        end
    end
`endif

    // Holding slot. A completed word is loaded unless the slot is full and not draining on this same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            po       <= '0;
            po_valid <= 1'b0;
`ifdef SHIFT_RX_PARITY_EN
            perr_q   <= 1'b0;
`endif
        end else if (accept) begin
            po       <= word;
            po_valid <= 1'b1;
`ifdef SHIFT_RX_PARITY_EN
            perr_q   <= word_perr;
`endif
        end else if (transfer) begin
            po_valid <= 1'b0;
        end
    end

    // Sticky overrun: a word finished while the slot was full and the consumer was not taking it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (complete && po_valid && !po_ready) begin
            overrun <= 1'b1;
        end
    end

    assign busy = (state == ST_ASSEMBLE);

`ifdef SHIFT_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
